// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO bus: region nibbles, device offsets,
// keyboard status bit positions and reset colours.
package mmio_pkg;

    localparam logic [3:0] REG_RAM  = 4'h0;
    localparam logic [3:0] REG_VRAM = 4'h1;
    localparam logic [3:0] REG_ROM  = 4'h2;
    localparam logic [3:0] REG_DEV  = 4'hF;

    localparam logic [7:0] OFF_SWITCH    = 8'h00;
    localparam logic [7:0] OFF_VGAMODE   = 8'h04;
    localparam logic [7:0] OFF_FORECOLOR = 8'h08;
    localparam logic [7:0] OFF_BACKCOLOR = 8'h0C;
    localparam logic [7:0] OFF_KBD_DATA  = 8'h10;
    localparam logic [7:0] OFF_KBD_STAT  = 8'h14;
    localparam logic [7:0] OFF_TIMER_CNT = 8'h18;
    localparam logic [7:0] OFF_TIMER_CMP = 8'h1C;
    localparam logic [7:0] OFF_SEG_BASE  = 8'h20;

    localparam int STAT_NONEMPTY = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_OVF      = 2;

    localparam logic [11:0] RST_FORECOLOR = 12'h000;
    localparam logic [11:0] RST_BACKCOLOR = 12'hFFF;

    typedef enum logic [2:0] {
        RG_NONE,
        RG_RAM,
        RG_VRAM,
        RG_ROM,
        RG_DEV
    } region_e;

    // The device page is only the first 256 bytes of the 0xF region.
    function automatic region_e decode_region(input logic [31:0] a);
        case (a[31:28])
            REG_RAM:  return RG_RAM;
            REG_VRAM: return RG_VRAM;
            REG_ROM:  return RG_ROM;
            REG_DEV:  return (a[27:8] == 20'h0) ? RG_DEV : RG_NONE;
            default:  return RG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Scancode FIFO; a pop in the same cycle frees the slot a push needs,
// so a push into a full FIFO is accepted when it is paired with a pop.
module kbd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_cnt;
    logic          w_pop;
    logic          w_push;

    assign full   = (r_cnt == (AW+1)'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign count  = r_cnt;
    assign dout   = r_mem[r_rd];
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/mmio_bus.sv
// CPU memory-mapped bus: RAM/VRAM/ROM pass-through plus a device page
// (switches, VGA, keyboard FIFO, seg7). Timer built only with MMIO_TIMER_EN.
module mmio_bus
    import mmio_pkg::*;
#(
    parameter int RAM_AW    = 12,
    parameter int KBD_DEPTH = 8,
    parameter int SEG_CH    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr4CPU,
    input  logic [31:0]           data4CPU,
    input  logic                  we4CPU,
    input  logic                  re4CPU,
    output logic [31:0]           data2CPU,
    output logic [RAM_AW-1:0]     addr2RAM,
    input  logic [31:0]           data4RAM,
    output logic [31:0]           data2RAM,
    output logic                  we2RAM,
    output logic [31:0]           addr2VRAM,
    input  logic [11:0]           data4VRAM,
    output logic [11:0]           data2VRAM,
    output logic                  we2VRAM,
    output logic [31:0]           addr2ROM,
    input  logic [31:0]           data4ROM,
    input  logic [15:0]           switch,
    output logic [32*SEG_CH-1:0]  seg7led,
    output logic                  VGAmode,
    output logic [11:0]           forecolor,
    output logic [11:0]           backcolor,
    input  logic                  KBDready,
    input  logic [7:0]            scancode,
    output logic                  KBDread,
    output logic                  timer_irq
);
    localparam int CW = $clog2(KBD_DEPTH) + 1;

    region_e                 w_region;
    logic [7:0]              w_off;
    logic                    w_sel_dev;
    logic                    w_wr_dev;
    logic                    w_seg_hit;
    logic [2:0]              w_seg_idx;
    logic [7:0][31:0]        w_seg_all;
    logic [SEG_CH-1:0][31:0] r_seg;
    logic                    r_vgamode;
    logic [11:0]             r_fore;
    logic [11:0]             r_back;
    logic                    r_kbdread;
    logic                    r_ovf;
    logic                    w_kbd_push;
    logic                    w_kbd_pop;
    logic                    w_kbd_drop;
    logic [7:0]              w_kbd_dout;
    logic [CW-1:0]           w_kbd_count;
    logic                    w_kbd_full;
    logic                    w_kbd_empty;
    logic [31:0]             w_kbd_stat;
    logic [31:0]             w_dev_rd;

    assign w_region  = decode_region(addr4CPU);
    assign w_off     = addr4CPU[7:0];
    assign w_sel_dev = (w_region == RG_DEV);
    assign w_wr_dev  = we4CPU & w_sel_dev;
    assign w_seg_hit = (w_off[7:5] == OFF_SEG_BASE[7:5]) && (w_off[1:0] == 2'b00);
    assign w_seg_idx = w_off[4:2];

    assign addr2RAM  = addr4CPU[RAM_AW+1:2];
    assign data2RAM  = data4CPU;
    assign we2RAM    = we4CPU & (w_region == RG_RAM);
    assign addr2VRAM = {10'h0, addr4CPU[21:0]};
    assign data2VRAM = data4CPU[11:0];
    assign we2VRAM   = we4CPU & (w_region == RG_VRAM);
    assign addr2ROM  = addr4CPU;

    assign seg7led   = r_seg;
    assign VGAmode   = r_vgamode;
    assign forecolor = r_fore;
    assign backcolor = r_back;
    assign KBDread   = r_kbdread;

    // Pad to 8 slots so unused slots read as zero without a range check.
    for (genvar g = 0; g < 8; g++) begin : g_seg
        if (g < SEG_CH) begin : g_used
            assign w_seg_all[g] = r_seg[g];
        end else begin : g_unused
            assign w_seg_all[g] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg     <= '0;
            r_vgamode <= 1'b0;
            r_fore    <= RST_FORECOLOR;
            r_back    <= RST_BACKCOLOR;
        end else if (w_wr_dev) begin
            if (w_off == OFF_VGAMODE)   r_vgamode <= data4CPU[0];
            if (w_off == OFF_FORECOLOR) r_fore    <= data4CPU[11:0];
            if (w_off == OFF_BACKCOLOR) r_back    <= data4CPU[11:0];
            for (int i = 0; i < SEG_CH; i++)
                if (w_seg_hit && w_seg_idx == 3'(i))
                    r_seg[i] <= data4CPU;
        end
    end

    // Keyboard 4-phase handshake: ack on the edge after a request is seen,
    // release on the edge after the request drops.
    assign w_kbd_push = KBDready & ~r_kbdread;
    assign w_kbd_pop  = re4CPU & w_sel_dev & (w_off == OFF_KBD_DATA);
    assign w_kbd_drop = w_kbd_push & w_kbd_full & ~w_kbd_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kbdread <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_kbd_push)
                r_kbdread <= 1'b1;
            else if (r_kbdread && !KBDready)
                r_kbdread <= 1'b0;
            if (w_kbd_drop)
                r_ovf <= 1'b1;
            else if (w_wr_dev && w_off == OFF_KBD_STAT && data4CPU[STAT_OVF])
                r_ovf <= 1'b0;
        end
    end

    kbd_fifo #(.DEPTH(KBD_DEPTH)) u_kbd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_kbd_push),
        .pop   (w_kbd_pop),
        .din   (scancode),
        .dout  (w_kbd_dout),
        .count (w_kbd_count),
        .full  (w_kbd_full),
        .empty (w_kbd_empty)
    );

    always_comb begin
        w_kbd_stat                = '0;
        w_kbd_stat[15:8]          = 8'(w_kbd_count);
        w_kbd_stat[STAT_OVF]      = r_ovf;
        w_kbd_stat[STAT_FULL]     = w_kbd_full;
        w_kbd_stat[STAT_NONEMPTY] = ~w_kbd_empty;
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] r_tcnt;
    logic [31:0] r_tcmp;
    logic        r_irq;

    // A compare write in a match cycle wins, so the irq stays low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
            r_tcmp <= '1;
            r_irq  <= 1'b0;
        end else begin
            r_tcnt <= r_tcnt + 32'd1;
            if (w_wr_dev && w_off == OFF_TIMER_CMP) begin
                r_tcmp <= data4CPU;
                r_irq  <= 1'b0;
            end else if (r_tcnt == r_tcmp) begin
                r_irq  <= 1'b1;
            end
        end
    end

    assign timer_irq = r_irq;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        w_dev_rd = '0;
        case (w_off)
            OFF_SWITCH:    w_dev_rd = {16'h0, switch};
            OFF_VGAMODE:   w_dev_rd = {31'h0, r_vgamode};
            OFF_FORECOLOR: w_dev_rd = {20'h0, r_fore};
            OFF_BACKCOLOR: w_dev_rd = {20'h0, r_back};
            OFF_KBD_DATA:  w_dev_rd = w_kbd_empty ? 32'h0 : {23'h0, 1'b1, w_kbd_dout};
            OFF_KBD_STAT:  w_dev_rd = w_kbd_stat;
`ifdef MMIO_TIMER_EN
            OFF_TIMER_CNT: w_dev_rd = r_tcnt;
            OFF_TIMER_CMP: w_dev_rd = r_tcmp;
`else
            OFF_TIMER_CNT, OFF_TIMER_CMP: w_dev_rd = '0;
`endif
            default:       if (w_seg_hit) w_dev_rd = w_seg_all[w_seg_idx];
        endcase
    end

    always_comb begin
        data2CPU = '0;
        case (w_region)
            RG_RAM:  data2CPU = data4RAM;
            RG_VRAM: data2CPU = {20'h0, data4VRAM};
            RG_ROM:  data2CPU = data4ROM;
            RG_DEV:  data2CPU = w_dev_rd;
            default: data2CPU = '0;
        endcase
    end

endmodule

// File: tb/tb_mmio_bus.sv
// Directed bench for mmio_bus: decode, device registers, keyboard FIFO,
// reset behaviour and (when MMIO_TIMER_EN is defined) the timer.
module tb_mmio_bus;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr4CPU, data4CPU;
    logic        we4CPU, re4CPU;
    logic [31:0] data2CPU;
    logic [11:0] addr2RAM;
    logic [31:0] data4RAM, data2RAM;
    logic        we2RAM;
    logic [31:0] addr2VRAM;
    logic [11:0] data4VRAM, data2VRAM;
    logic        we2VRAM;
    logic [31:0] addr2ROM, data4ROM;
    logic [15:0] switch;
    logic [63:0] seg7led;
    logic        VGAmode;
    logic [11:0] forecolor, backcolor;
    logic        KBDready;
    logic [7:0]  scancode;
    logic        KBDread;
    logic        timer_irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mmio_bus #(.RAM_AW(12), .KBD_DEPTH(8), .SEG_CH(2)) dut (
        .clk(clk), .rst(rst),
        .addr4CPU(addr4CPU), .data4CPU(data4CPU), .we4CPU(we4CPU), .re4CPU(re4CPU),
        .data2CPU(data2CPU),
        .addr2RAM(addr2RAM), .data4RAM(data4RAM), .data2RAM(data2RAM), .we2RAM(we2RAM),
        .addr2VRAM(addr2VRAM), .data4VRAM(data4VRAM), .data2VRAM(data2VRAM), .we2VRAM(we2VRAM),
        .addr2ROM(addr2ROM), .data4ROM(data4ROM),
        .switch(switch), .seg7led(seg7led), .VGAmode(VGAmode),
        .forecolor(forecolor), .backcolor(backcolor),
        .KBDready(KBDready), .scancode(scancode), .KBDread(KBDread),
        .timer_irq(timer_irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr4CPU = a; data4CPU = d; we4CPU = 1'b1;
        tick;
        we4CPU = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic pop, output logic [31:0] d);
        addr4CPU = a; re4CPU = pop;
        #1 d = data2CPU;
        if (pop) begin
            tick;
            re4CPU = 1'b0;
        end
    endtask

    task automatic wait_kbdread(input logic v, input string tag);
        int n = 0;
        while (KBDread !== v && n < 20) begin
            tick;
            n++;
        end
        chk(tag, {31'h0, KBDread}, {31'h0, v});
    endtask

    task automatic kbd_push(input logic [7:0] b);
        scancode = b; KBDready = 1'b1;
        wait_kbdread(1'b1, "hs_ack");
        KBDready = 1'b0;
        wait_kbdread(1'b0, "hs_rel");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        rst = 1'b1; addr4CPU = '0; data4CPU = '0; we4CPU = 1'b0; re4CPU = 1'b0;
        data4RAM = 32'hA5A50001; data4VRAM = 12'h3C7; data4ROM = 32'h0BADF00D;
        switch = 16'hBEEF; KBDready = 1'b0; scancode = '0;
        tick; tick;
        rst = 1'b0;

        // Reset state
        chk("rst_seg_lo", seg7led[31:0], 32'h0);
        chk("rst_seg_hi", seg7led[63:32], 32'h0);
        chk("rst_vga", {31'h0, VGAmode}, 32'h0);
        chk("rst_fore", {20'h0, forecolor}, 32'h0);
        chk("rst_back", {20'h0, backcolor}, 32'hFFF);
        chk("rst_kbdread", {31'h0, KBDread}, 32'h0);
        chk("rst_irq", {31'h0, timer_irq}, 32'h0);
        rd(32'hF0000014, 1'b0, d); chk("rst_stat", d, 32'h0);

        // Region decode, combinational
        addr4CPU = 32'h00000010; data4CPU = 32'h11223344; we4CPU = 1'b1;
        #1;
        chk("ram_we", {31'h0, we2RAM}, 32'h1);
        chk("ram_vwe", {31'h0, we2VRAM}, 32'h0);
        chk("ram_addr", {20'h0, addr2RAM}, 32'h4);
        chk("ram_wdata", data2RAM, 32'h11223344);
        chk("ram_rdata", data2CPU, 32'hA5A50001);
        addr4CPU = 32'h10123456;
        #1;
        chk("vram_we", {31'h0, we2VRAM}, 32'h1);
        chk("vram_rwe", {31'h0, we2RAM}, 32'h0);
        chk("vram_addr", addr2VRAM, 32'h00123456);
        chk("vram_wdata", {20'h0, data2VRAM}, 32'h344);
        chk("vram_rdata", data2CPU, 32'h3C7);
        we4CPU = 1'b0;
        rd(32'h20000040, 1'b0, d); chk("rom_rdata", d, 32'h0BADF00D);
        chk("rom_addr", addr2ROM, 32'h20000040);
        rd(32'h30000000, 1'b0, d); chk("unmapped_rd", d, 32'h0);
        rd(32'hF0000000, 1'b0, d); chk("switch_rd", d, 32'h0000BEEF);
        rd(32'hF1000000, 1'b0, d); chk("devhi_rd", d, 32'h0);
        rd(32'hF0000044, 1'b0, d); chk("dev_unlisted", d, 32'h0);

        // Seg7 channel 1 and VGA registers
        wr(32'hF0000024, 32'h12345678);
        chk("seg1", seg7led[63:32], 32'h12345678);
        chk("seg0_keep", seg7led[31:0], 32'h0);
        rd(32'hF0000024, 1'b0, d); chk("seg1_rd", d, 32'h12345678);
        wr(32'hF0000004, 32'hFFFFFFFF);
        rd(32'hF0000004, 1'b0, d); chk("vga_rd", d, 32'h1);
        wr(32'hF0000008, 32'h00000ABC);
        chk("fore", {20'h0, forecolor}, 32'hABC);
        wr(32'hF0000028, 32'hDEADBEEF);
        rd(32'hF0000028, 1'b0, d); chk("seg_unused", d, 32'h0);

        // Three scancodes in, three out, then empty
        kbd_push(8'h1C); kbd_push(8'h32); kbd_push(8'h21);
        rd(32'hF0000014, 1'b0, d); chk("stat3", d, 32'h00000301);
        rd(32'hF0000010, 1'b1, d); chk("pop1", d, 32'h0000011C);
        rd(32'hF0000010, 1'b1, d); chk("pop2", d, 32'h00000132);
        rd(32'hF0000010, 1'b1, d); chk("pop3", d, 32'h00000121);
        rd(32'hF0000010, 1'b1, d); chk("pop_empty", d, 32'h0);
        rd(32'hF0000014, 1'b0, d); chk("stat_empty", d, 32'h0);

        // Overflow: nine pushes into an eight-deep FIFO
        for (int k = 0; k < 9; k++) kbd_push(8'h40 + 8'(k));
        rd(32'hF0000014, 1'b0, d); chk("stat_ovf", d, 32'h00000807);
        wr(32'hF0000014, 32'h4);
        rd(32'hF0000014, 1'b0, d); chk("stat_ovf_clr", d, 32'h00000803);

        // Full FIFO: pop and push on the same edge
        addr4CPU = 32'hF0000010; re4CPU = 1'b1; scancode = 8'h77; KBDready = 1'b1;
        #1 chk("pp_head", data2CPU, 32'h00000140);
        tick;
        re4CPU = 1'b0; KBDready = 1'b0;
        chk("pp_ack", {31'h0, KBDread}, 32'h1);
        rd(32'hF0000014, 1'b0, d); chk("pp_stat", d, 32'h00000803);
        tick;
        for (int k = 1; k < 8; k++) begin
            rd(32'hF0000010, 1'b1, d); chk("pp_drain", d, 32'h00000140 + 32'(k));
        end
        rd(32'hF0000010, 1'b1, d); chk("pp_last", d, 32'h00000177);
        rd(32'hF0000014, 1'b0, d); chk("pp_stat_end", d, 32'h0);

        // Reset in the middle of a handshake
        kbd_push(8'h11);
        scancode = 8'h22; KBDready = 1'b1;
        tick;
        chk("mid_ack", {31'h0, KBDread}, 32'h1);
        rd(32'hF0000014, 1'b0, d); chk("mid_stat", d, 32'h00000201);
        rst = 1'b1;
        tick;
        chk("mid_rst_ack", {31'h0, KBDread}, 32'h0);
        rd(32'hF0000014, 1'b0, d); chk("mid_rst_stat", d, 32'h0);
        KBDready = 1'b0; rst = 1'b0;
        chk("rst2_seg", seg7led[63:32], 32'h0);
        chk("rst2_back", {20'h0, backcolor}, 32'hFFF);
        wr(32'hF0000100, 32'hDEADBEEF);
        chk("off_page_seg", seg7led[31:0], 32'h0);
        chk("off_page_vga", {31'h0, VGAmode}, 32'h0);
        chk("off_page_back", {20'h0, backcolor}, 32'hFFF);
        rd(32'hF0000100, 1'b0, d); chk("off_page_rd", d, 32'h0);
        kbd_push(8'h33);
        rd(32'hF0000014, 1'b0, d); chk("restart_stat", d, 32'h00000101);

        // Timer
        rst = 1'b1; tick; rst = 1'b0;
`ifdef MMIO_TIMER_EN
        wr(32'hF000001C, 32'd20);
        begin
            int n = 0;
            rd(32'hF0000018, 1'b0, d);
            while (d != 32'd20 && n < 100) begin
                tick; n++;
                rd(32'hF0000018, 1'b0, d);
            end
            chk("tmr_reach", d, 32'd20);
        end
        chk("tmr_irq_pre", {31'h0, timer_irq}, 32'h0);
        tick;
        chk("tmr_irq", {31'h0, timer_irq}, 32'h1);
        tick;
        chk("tmr_irq_hold", {31'h0, timer_irq}, 32'h1);
        wr(32'hF000001C, 32'd5000);
        chk("tmr_irq_clr", {31'h0, timer_irq}, 32'h0);
`else
        tick; tick;
        chk("tmr_irq_off", {31'h0, timer_irq}, 32'h0);
        rd(32'hF0000018, 1'b0, d); chk("tmr_cnt_off", d, 32'h0);
        wr(32'hF000001C, 32'd20);
        rd(32'hF000001C, 1'b0, d); chk("tmr_cmp_off", d, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
